// File: rtl/timer_sched.sv
// timer_sched: tick scheduler and sole bus master of the interval timer.
// Optional overflow register (+11) is built when TIMER_SCHED_OVF_EN is defined.
module timer_sched #(
    parameter int unsigned NCH      = 4,
    parameter logic [15:0] BASE     = 16'hFF40,
    parameter logic [31:0] TICK_RST = 32'h004C4B40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] h_addr,
    input  logic        h_we,
    input  logic [7:0]  h_di,
    output logic [7:0]  h_do,
    output logic [15:0] t_addr,
    output logic        t_we,
    output logic [7:0]  t_do,
    input  logic [7:0]  t_di,
    output logic        irq
);

    localparam logic [15:0] ADDR_TMR_0    = 16'hFF30;
    localparam logic [15:0] ADDR_TMR_1    = 16'hFF31;
    localparam logic [15:0] ADDR_TMR_2    = 16'hFF32;
    localparam logic [15:0] ADDR_TMR_3    = 16'hFF33;
    localparam logic [15:0] ADDR_TMR_RST  = 16'hFF34;
    localparam logic [15:0] ADDR_TMR_TRIG = 16'hFF35;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PROG3 = 3'd1;
    localparam logic [2:0] S_PROG2 = 3'd2;
    localparam logic [2:0] S_PROG1 = 3'd3;
    localparam logic [2:0] S_PROG0 = 3'd4;
    localparam logic [2:0] S_CLR   = 3'd5;
    localparam logic [2:0] S_POLL  = 3'd6;

    localparam logic [15:0] OFF_CTRL = 16'd0;
    localparam logic [15:0] OFF_PER  = 16'd5;
    localparam logic [15:0] OFF_PEND = 16'd9;
    localparam logic [15:0] OFF_MASK = 16'd10;
    localparam logic [15:0] OFF_OVF  = 16'd11;

    logic [15:0]    off;
    logic           en;
    logic [31:0]    tick;
    logic [7:0]     period [NCH];
    logic [7:0]     cnt    [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] fire;
    logic [NCH-1:0] per_wr;
    logic [NCH-1:0] pend_clr;
    logic [NCH-1:0] ovf_rd;
    logic           wr_ctrl;
    logic           wr_tick;
    logic           wr_mask;
    logic           dirty;
    logic           tick_ev;
    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic           unused_t_di;

    assign off         = h_addr - BASE;
    assign unused_t_di = &{1'b0, t_di[7:1]};
    // The trigger flag is only read (and thus consumed) while polling.
    assign tick_ev     = en && (state == S_POLL) && t_di[0];

    always_comb begin
        wr_ctrl  = h_we && (off == OFF_CTRL);
        wr_tick  = h_we && (off >= 16'd1) && (off <= 16'd4);
        wr_mask  = h_we && (off == OFF_MASK);
        pend_clr = (h_we && (off == OFF_PEND)) ? h_di[NCH-1:0] : '0;
        per_wr   = '0;
        fire     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            per_wr[i] = h_we && (off == OFF_PER + 16'(i));
            fire[i]   = tick_ev && (period[i] != 8'd0) && (cnt[i] == period[i] - 8'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en   <= 1'b0;
            tick <= TICK_RST;
            mask <= '0;
        end else begin
            if (wr_ctrl) en <= h_di[0];
            if (wr_mask) mask <= h_di[NCH-1:0];
            if (wr_tick) begin
                case (off)
                    16'd1:   tick[31:24] <= h_di;
                    16'd2:   tick[23:16] <= h_di;
                    16'd3:   tick[15:8]  <= h_di;
                    16'd4:   tick[7:0]   <= h_di;
                    default: ;
                endcase
            end
        end
    end

    // A PERIOD write beats a simultaneous tick; disable clears every counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (per_wr[i]) period[i] <= h_di;
                if (!en || per_wr[i]) begin
                    cnt[i] <= '0;
                end else if (tick_ev && (period[i] != 8'd0)) begin
                    cnt[i] <= fire[i] ? 8'd0 : cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= (pend & ~pend_clr) | fire;
            irq  <= |(pend & mask);
        end
    end

`ifdef TIMER_SCHED_OVF_EN
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] ovf_clr;

    assign ovf_clr = (h_we && (off == OFF_OVF)) ? h_di[NCH-1:0] : '0;
    assign ovf_rd  = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= '0;
        else     ovf <= (ovf & ~ovf_clr) | (fire & pend);
    end
`else
    assign ovf_rd = '0;
`endif

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_PROG3;
                S_PROG3: state_nxt = S_PROG2;
                S_PROG2: state_nxt = S_PROG1;
                S_PROG1: state_nxt = S_PROG0;
                S_PROG0: state_nxt = S_CLR;
                S_CLR:   state_nxt = S_POLL;
                S_POLL:  state_nxt = dirty ? S_PROG3 : S_POLL;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            dirty  <= 1'b0;
            t_addr <= '0;
            t_we   <= 1'b0;
            t_do   <= '0;
        end else begin
            state <= state_nxt;
            if (wr_tick)                     dirty <= 1'b1;
            else if (state_nxt == S_PROG3)   dirty <= 1'b0;
            t_we   <= 1'b0;
            t_addr <= '0;
            t_do   <= '0;
            case (state_nxt)
                S_PROG3: begin t_we <= 1'b1; t_addr <= ADDR_TMR_3; t_do <= tick[31:24]; end
                S_PROG2: begin t_we <= 1'b1; t_addr <= ADDR_TMR_2; t_do <= tick[23:16]; end
                S_PROG1: begin t_we <= 1'b1; t_addr <= ADDR_TMR_1; t_do <= tick[15:8];  end
                S_PROG0: begin t_we <= 1'b1; t_addr <= ADDR_TMR_0; t_do <= tick[7:0];   end
                S_CLR:   begin t_we <= 1'b1; t_addr <= ADDR_TMR_RST; end
                S_POLL:  t_addr <= ADDR_TMR_TRIG;
                default: ;
            endcase
        end
    end

    always_comb begin
        h_do = '0;
        case (off)
            OFF_CTRL: h_do = {7'd0, en};
            16'd1:    h_do = tick[31:24];
            16'd2:    h_do = tick[23:16];
            16'd3:    h_do = tick[15:8];
            16'd4:    h_do = tick[7:0];
            OFF_PEND: h_do[NCH-1:0] = pend;
            OFF_MASK: h_do[NCH-1:0] = mask;
            OFF_OVF:  h_do[NCH-1:0] = ovf_rd;
            default: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (off == OFF_PER + 16'(i)) h_do = period[i];
                end
            end
        endcase
    end

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed scenarios plus randomized traffic against a
// cycle-level reference model of the scheduler (define TIMER_SCHED_OVF_EN for OVF).
module tb_timer_sched;

    localparam logic [15:0] BASE      = 16'hFF40;
    localparam logic [31:0] TICK_RST  = 32'h004C4B40;
    localparam logic [15:0] ADDR_TRIG = 16'hFF35;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] h_addr = '0;
    logic        h_we = 1'b0;
    logic [7:0]  h_di = '0;
    logic [7:0]  h_do;
    logic [15:0] t_addr;
    logic        t_we;
    logic [7:0]  t_do;
    logic [7:0]  t_di = '0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_sched #(.NCH(4), .BASE(BASE), .TICK_RST(TICK_RST)) dut (
        .clk(clk), .rst(rst), .h_addr(h_addr), .h_we(h_we), .h_di(h_di), .h_do(h_do),
        .t_addr(t_addr), .t_we(t_we), .t_do(t_do), .t_di(t_di), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1..4 byte writes (MSB first), 5 restart, 6 poll.
    logic        m_en;
    logic [31:0] m_tick;
    logic [7:0]  m_per [4];
    int          m_ticks [4];
    logic [3:0]  m_pend, m_mask, m_ovf;
    logic        m_irq, m_dirty;
    int          m_phase;
    logic [7:0]  m_tdo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_tick = TICK_RST; m_mask = '0; m_pend = '0; m_ovf = '0;
        m_irq = 1'b0; m_dirty = 1'b0; m_phase = 0; m_tdo = '0;
        for (int i = 0; i < 4; i++) begin m_per[i] = '0; m_ticks[i] = 0; end
    endtask

    function automatic logic [15:0] exp_addr(input int ph);
        case (ph)
            1: return 16'hFF33;
            2: return 16'hFF32;
            3: return 16'hFF31;
            4: return 16'hFF30;
            5: return 16'hFF34;
            6: return ADDR_TRIG;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE;
        case (o)
            16'd0:  return {7'd0, m_en};
            16'd1, 16'd2, 16'd3, 16'd4: return m_tick[8*(4-o) +: 8];
            16'd5, 16'd6, 16'd7, 16'd8: return m_per[o-5];
            16'd9:  return {4'd0, m_pend};
            16'd10: return {4'd0, m_mask};
`ifdef TIMER_SCHED_OVF_EN
            16'd11: return {4'd0, m_ovf};
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        logic [15:0] o;
        logic        tk;
        logic [3:0]  fire, clr;
        int          np;
        o    = h_addr - BASE;
        tk   = (m_phase == 6) && m_en && t_di[0];
        clr  = (h_we && o == 16'd9) ? h_di[3:0] : 4'h0;
        for (int ch = 0; ch < 4; ch++)
            fire[ch] = tk && (m_per[ch] != 0) && (((m_ticks[ch] + 1) % int'(m_per[ch])) == 0);
        m_irq = |(m_pend & m_mask);
        m_ovf = (m_ovf & ~((h_we && o == 16'd11) ? h_di[3:0] : 4'h0)) | (fire & m_pend);
        m_pend = (m_pend & ~clr) | fire;
        for (int ch = 0; ch < 4; ch++) begin
            if (!m_en || (h_we && o == 16'(5 + ch))) m_ticks[ch] = 0;
            else if (tk && m_per[ch] != 0) m_ticks[ch]++;
        end
        if (!m_en)           np = 0;
        else if (m_phase == 0) np = 1;
        else if (m_phase < 6)  np = m_phase + 1;
        else                   np = m_dirty ? 1 : 6;
        if (np >= 1 && np <= 4) m_tdo = m_tick[8*(4-np) +: 8];
        if (h_we && o >= 16'd1 && o <= 16'd4) m_dirty = 1'b1;
        else if (np == 1)                     m_dirty = 1'b0;
        m_phase = np;
        if (h_we) begin
            if (o == 16'd0) m_en = h_di[0];
            if (o >= 16'd1 && o <= 16'd4) m_tick[8*(4-o) +: 8] = h_di;
            if (o >= 16'd5 && o <= 16'd8) m_per[o-5] = h_di;
            if (o == 16'd10) m_mask = h_di[3:0];
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("t_addr", t_addr, exp_addr(m_phase));
        check("t_we", t_we, (m_phase >= 1 && m_phase <= 5));
        if (m_phase >= 1 && m_phase <= 4) check("t_do", t_do, m_tdo);
        if (rst) check("t_do_rst", t_do, 8'h00);
        check("irq", irq, m_irq);
        check("h_do", h_do, m_read(h_addr));
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
        h_addr = a; h_di = d; h_we = 1'b1;
        cycle();
        h_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        h_addr = a;
        #1;
        d = h_do;
    endtask

    task automatic wait_poll();
        int n = 0;
        while (t_addr !== ADDR_TRIG && n < 30) begin cycle(); n++; end
        check("poll_wait", t_addr, ADDR_TRIG);
    endtask

    task automatic pulse();
        t_di = 8'h01; cycle(); t_di = 8'h00; cycle();
    endtask

    logic [15:0] seq_addr [6];
    logic [7:0]  seq_do   [4];
    logic [7:0]  rst_tick [4];

    initial begin
        logic [7:0] d;
        int         o;
        model_reset();
        rst_tick = '{8'h00, 8'h4C, 8'h4B, 8'h40};
        seq_addr = '{16'hFF33, 16'hFF32, 16'hFF31, 16'hFF30, 16'hFF34, ADDR_TRIG};

        // Reset values, then enable and watch the programming sequence.
        repeat (2) cycle();
        check("rst_t_addr", t_addr, 16'h0000);
        check("rst_t_we", t_we, 1'b0);
        check("rst_irq", irq, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 16'(1 + i), d);
            check("rst_tick", d, rst_tick[i]);
            cycle();
        end
        rst = 1'b0;
        cycle();
        host_wr(BASE, 8'h01);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("prog_addr", t_addr, seq_addr[k]);
            if (k < 4) check("prog_do", t_do, rst_tick[k]);
        end

        // TICK=9, PERIOD0=3, MASK=1: fires on the third tick, irq 2 cycles later.
        host_wr(BASE + 16'd1, 8'h00);
        host_wr(BASE + 16'd2, 8'h00);
        host_wr(BASE + 16'd3, 8'h00);
        host_wr(BASE + 16'd4, 8'h09);
        host_wr(BASE + 16'd5, 8'h03);
        host_wr(BASE + 16'd10, 8'h01);
        repeat (12) cycle();
        wait_poll();
        pulse();
        pulse();
        rd(BASE + 16'd9, d);
        check("pend_after2", d, 8'h00);
        t_di = 8'h01; cycle(); t_di = 8'h00;
        check("irq_lat1", irq, 1'b0);
        cycle();
        check("irq_lat2", irq, 1'b1);
        host_wr(BASE + 16'd9, 8'h01);
        check("irq_hold", irq, 1'b1);
        cycle();
        check("irq_fall", irq, 1'b0);

        // PERIOD1=1: clear and set of PEND1 in the same cycle leaves it set.
        host_wr(BASE + 16'd6, 8'h01);
        h_addr = BASE + 16'd9; h_di = 8'h02; h_we = 1'b1; t_di = 8'h01;
        cycle();
        h_we = 1'b0; t_di = 8'h00;
        rd(BASE + 16'd9, d);
        check("pend1_setwins", (d >> 1) & 8'h01, 8'h01);

        // TICK0 write while polling forces a full reprogram with the new value.
        seq_do = '{8'h00, 8'h00, 8'h00, 8'h20};
        host_wr(BASE + 16'd4, 8'h20);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("reprog_addr", t_addr, seq_addr[k]);
            if (k < 4) check("reprog_do", t_do, seq_do[k]);
        end
        cycle();

        // Disable lands during PROG1: idle on the next cycle, PEND kept.
        host_wr(BASE + 16'd4, 8'h21);
        cycle();
        cycle();
        host_wr(BASE, 8'h00);
        check("dis_prog1", t_addr, 16'hFF31);
        cycle();
        check("dis_we", t_we, 1'b0);
        check("dis_addr", t_addr, 16'h0000);
        rd(BASE + 16'd9, d);
        check("dis_pend", d, 8'h02);

        // Two firings without clearing PEND raise OVF (when built in).
        host_wr(BASE + 16'd5, 8'h01);
        host_wr(BASE + 16'd9, 8'hFF);
        host_wr(BASE + 16'd11, 8'hFF);
        host_wr(BASE, 8'h01);
        repeat (8) cycle();
        wait_poll();
        pulse();
        pulse();
        rd(BASE + 16'd11, d);
`ifdef TIMER_SCHED_OVF_EN
        check("ovf", d, 8'h03);
`else
        check("ovf", d, 8'h00);
`endif
        host_wr(BASE + 16'd11, 8'hFF);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            t_di = 8'($urandom);
            t_di[0] = ($urandom_range(0, 3) == 0);
            if (c == 1500) begin rst = 1'b1; model_reset(); end
            if (c == 1502) rst = 1'b0;
            h_we = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                o = $urandom_range(0, 13);
                d = 8'($urandom);
                if (o == 0) d = {7'd0, ($urandom_range(0, 9) != 0)};
                else if (o >= 5 && o <= 8) d = 8'($urandom_range(0, 4));
                h_addr = BASE + 16'(o); h_di = d; h_we = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                h_addr = 16'($urandom);
            end else begin
                h_addr = BASE + 16'($urandom_range(0, 15));
            end
            cycle();
        end
        h_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
